// File: rtl/mouse_bus_pkg.sv
// Shared definitions for the mouse bus register block.
// Contents:
//   - register offsets, relative to the block base address
//   - bit positions inside the mouse status byte
//   - a helper that clamps a value loaded from the bus
package mouse_bus_pkg;

  // Register offsets inside the block.
  localparam logic [2:0] OFS_STATUS  = 3'd0;
  localparam logic [2:0] OFS_POS_X   = 3'd1;
  localparam logic [2:0] OFS_POS_Y   = 3'd2;
  localparam logic [2:0] OFS_DX      = 3'd3;
  localparam logic [2:0] OFS_DY      = 3'd4;
  localparam logic [2:0] OFS_PKT_CNT = 3'd5;
  localparam logic [2:0] OFS_FLAGS   = 3'd6;

  // Number of registers; offsets at or above this are outside the block.
  localparam logic [7:0] REG_COUNT = 8'd7;

  // Bit positions inside the mouse status byte.
  localparam int X_SIGN = 4;
  localparam int Y_SIGN = 5;
  localparam int X_OVF  = 6;
  localparam int Y_OVF  = 7;

  // A position written by the processor saturates at the axis maximum.
  function automatic logic [7:0] clampLoad(input logic [7:0] value,
                                           input logic [7:0] maxVal);
    return (value > maxVal) ? maxVal : value;
  endfunction

endpackage

// File: rtl/mouse_bus_regs_if.sv
// Processor bus and mouse packet signals seen by mouse_bus_regs.
// BUS_DATA is not carried here: it is a tristate net and stays a plain
// inout port on the top module, so its drivers resolve in one place.
// Signals:
//   BUS_ADDR, BUS_WE        processor address and write enable
//   MOUSE_STATUS/DX/DY      decoded 3-byte packet
//   MOUSE_VALID             one-cycle strobe, packet bytes valid
//   BUS_INTERRUPT_RAISE     interrupt request to processor
//   BUS_INTERRUPT_ACK       one-cycle acknowledge from processor
// Modports:
//   master  processor + mouse receiver side
//   slave   the register block
interface mouse_bus_regs_if;

  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       MOUSE_VALID;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;

  modport master (
    output BUS_ADDR, BUS_WE,
    output MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_VALID,
    output BUS_INTERRUPT_ACK,
    input  BUS_INTERRUPT_RAISE
  );

  modport slave (
    input  BUS_ADDR, BUS_WE,
    input  MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_VALID,
    input  BUS_INTERRUPT_ACK,
    output BUS_INTERRUPT_RAISE
  );

endinterface

// File: rtl/mouse_axis_accum.sv
// One axis of the absolute pointer position.
// Adds a 9-bit signed mouse delta to the position and saturates the
// result to 0..MAX. A processor load takes priority over a packet update
// in the same cycle.
// Parameters:
//   MAX      inclusive upper clamp
//   INVERT   1 = subtract the delta (screen Y grows downwards)
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   delta_i, sign_i  delta magnitude byte and its sign bit
//   ovf_i            packet overflow for this axis, delta ignored
//   update_i         packet strobe
//   load_i           processor write to this axis
//   loadData_i       value written by the processor
//   pos_o            current clamped position
module mouse_axis_accum
  import mouse_bus_pkg::*;
#(
  parameter logic [7:0] MAX    = 8'd159,
  parameter bit         INVERT = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] delta_i,
  input  logic       sign_i,
  input  logic       ovf_i,
  input  logic       update_i,
  input  logic       load_i,
  input  logic [7:0] loadData_i,
  output logic [7:0] pos_o
);

  logic [7:0]        pos_q;
  logic [7:0]        pos_d;
  logic signed [9:0] step;
  logic signed [9:0] sum;

  // Ten bits hold every reachable result: 0..255 position plus a delta
  // of -256..255. A negative sum saturates to 0, anything above MAX to MAX.
  always_comb begin
    step  = ovf_i ? 10'sd0 : $signed({sign_i, sign_i, delta_i});
    sum   = INVERT ? ($signed({2'b00, pos_q}) - step)
                   : ($signed({2'b00, pos_q}) + step);
    pos_d = pos_q;
    if (load_i) begin
      pos_d = clampLoad(loadData_i, MAX);
    end else if (update_i) begin
      if (sum[9]) begin
        pos_d = 8'd0;
      end else if (sum > $signed({2'b00, MAX})) begin
        pos_d = MAX;
      end else begin
        pos_d = sum[7:0];
      end
    end
  end

  // Position starts at the middle of the axis.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pos_q <= MAX >> 1;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/mouse_bus_regs.sv
// Read-side bus responder for the PS/2 mouse.
// Accumulates decoded mouse packets into a clamped absolute pointer
// position and exposes seven registers at BASE_ADDR..BASE_ADDR+6:
//   +0 status  +1 pos_x (RW)  +2 pos_y (RW)  +3 dx  +4 dy
//   +5 packet count  +6 flags (bit0 = overrun)
// A read addressed in cycle N is driven onto BUS_DATA during cycle N+1;
// the bus is high impedance at all other times. Each packet raises the
// interrupt until the processor acknowledges it.
// Ports:
//   clk_sys    system clock
//   rst_n      async active-low reset
//   BUS_DATA   shared tristate data bus
//   bus        address/control/mouse/interrupt signals (slave modport)
module mouse_bus_regs
  import mouse_bus_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hA0,
  parameter logic [7:0] MAX_X     = 8'd159,
  parameter logic [7:0] MAX_Y     = 8'd119
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  inout  wire [7:0]       BUS_DATA,
  mouse_bus_regs_if.slave bus
);

  logic [7:0] offset;
  logic       inRange;
  logic [2:0] regSel;
  logic       rdReq;
  logic       wrX;
  logic       wrY;
  logic       rdFlags;
  logic       ovrSet;
  logic [7:0] posX;
  logic [7:0] posY;
  logic [7:0] rdMux;

  logic [7:0] status_q, status_d;
  logic [7:0] dx_q, dx_d;
  logic [7:0] dy_q, dy_d;
  logic [7:0] pktCnt_q, pktCnt_d;
  logic [7:0] rdData_q, rdData_d;
  logic       overrun_q, overrun_d;
  logic       raise_q, raise_d;
  logic       rdEn_q, rdEn_d;

  // Subtracting the base first means addresses below the base wrap to
  // large offsets and fall out of range with a single compare.
  assign offset  = bus.BUS_ADDR - BASE_ADDR;
  assign inRange = (offset < REG_COUNT);
  assign regSel  = offset[2:0];
  assign rdReq   = !bus.BUS_WE && inRange;
  assign wrX     = bus.BUS_WE && inRange && (regSel == OFS_POS_X);
  assign wrY     = bus.BUS_WE && inRange && (regSel == OFS_POS_Y);
  assign rdFlags = rdReq && (regSel == OFS_FLAGS);
  assign ovrSet  = bus.MOUSE_VALID && raise_q && !bus.BUS_INTERRUPT_ACK;

  mouse_axis_accum #(.MAX(MAX_X), .INVERT(1'b0)) u_axisX (
    .clk_i      (clk_sys),
    .rst_n_i    (rst_n),
    .delta_i    (bus.MOUSE_DX),
    .sign_i     (bus.MOUSE_STATUS[X_SIGN]),
    .ovf_i      (bus.MOUSE_STATUS[X_OVF]),
    .update_i   (bus.MOUSE_VALID),
    .load_i     (wrX),
    .loadData_i (BUS_DATA),
    .pos_o      (posX)
  );

  mouse_axis_accum #(.MAX(MAX_Y), .INVERT(1'b1)) u_axisY (
    .clk_i      (clk_sys),
    .rst_n_i    (rst_n),
    .delta_i    (bus.MOUSE_DY),
    .sign_i     (bus.MOUSE_STATUS[Y_SIGN]),
    .ovf_i      (bus.MOUSE_STATUS[Y_OVF]),
    .update_i   (bus.MOUSE_VALID),
    .load_i     (wrY),
    .loadData_i (BUS_DATA),
    .pos_o      (posY)
  );

  // Read mux samples the registers as they stand in the address cycle,
  // so a packet strobed one cycle earlier is already visible.
  always_comb begin
    rdMux = 8'h00;
    case (regSel)
      OFS_STATUS:  rdMux = status_q;
      OFS_POS_X:   rdMux = posX;
      OFS_POS_Y:   rdMux = posY;
      OFS_DX:      rdMux = dx_q;
      OFS_DY:      rdMux = dy_q;
      OFS_PKT_CNT: rdMux = pktCnt_q;
      OFS_FLAGS:   rdMux = {7'd0, overrun_q};
      default:     rdMux = 8'h00;
    endcase
  end

  // Next-state: packet latch and counter, interrupt (a new packet beats
  // an acknowledge), overrun (a new overrun beats a read-clear), and the
  // one-cycle read response pipeline.
  always_comb begin
    status_d  = status_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    pktCnt_d  = pktCnt_q;
    raise_d   = raise_q;
    overrun_d = overrun_q;
    rdEn_d    = rdReq;
    rdData_d  = rdData_q;

    if (bus.MOUSE_VALID) begin
      status_d = bus.MOUSE_STATUS;
      dx_d     = bus.MOUSE_DX;
      dy_d     = bus.MOUSE_DY;
      pktCnt_d = pktCnt_q + 8'd1;
    end

    if (bus.MOUSE_VALID) begin
      raise_d = 1'b1;
    end else if (bus.BUS_INTERRUPT_ACK) begin
      raise_d = 1'b0;
    end

    if (ovrSet) begin
      overrun_d = 1'b1;
    end else if (rdFlags) begin
      overrun_d = 1'b0;
    end

    if (rdReq) begin
      rdData_d = rdMux;
    end
  end

  // All state clears asynchronously; clearing rdEn releases the bus at
  // the moment reset is asserted, even mid-response.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      status_q  <= 8'h00;
      dx_q      <= 8'h00;
      dy_q      <= 8'h00;
      pktCnt_q  <= 8'h00;
      rdData_q  <= 8'h00;
      overrun_q <= 1'b0;
      raise_q   <= 1'b0;
      rdEn_q    <= 1'b0;
    end else begin
      status_q  <= status_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      pktCnt_q  <= pktCnt_d;
      rdData_q  <= rdData_d;
      overrun_q <= overrun_d;
      raise_q   <= raise_d;
      rdEn_q    <= rdEn_d;
    end
  end

  assign BUS_DATA                = rdEn_q ? rdData_q : 8'hzz;
  assign bus.BUS_INTERRUPT_RAISE = raise_q;

endmodule

// File: tb/tb_mouse_bus_regs.sv
// Self-checking bench for mouse_bus_regs.
// BUS_DATA is pulled up, so a released bus reads as 8'hFF.
// Reads push the model's expected value into a queue; the response is
// popped and compared on the falling edge of the response cycle.
module tb_mouse_bus_regs;

  logic clk_sys = 1'b0;
  logic rst_n;

  tri1 [7:0] BUS_DATA;
  logic       tbDrive;
  logic [7:0] tbData;
  assign BUS_DATA = tbDrive ? tbData : 8'hzz;

  mouse_bus_regs_if busIf ();

  mouse_bus_regs #(
    .BASE_ADDR (8'hA0),
    .MAX_X     (8'd159),
    .MAX_Y     (8'd119)
  ) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .BUS_DATA (BUS_DATA),
    .bus      (busIf)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  logic [7:0] expQ[$];
  logic [7:0] addrQ[$];

  // Model of the register block.
  int         mdlX;
  int         mdlY;
  logic [7:0] mdlCnt;
  logic [7:0] mdlStatus;
  logic [7:0] mdlDx;
  logic [7:0] mdlDy;
  logic       mdlRaise;
  logic       mdlOvr;

  // Which falling edges carry a read response or the release after it.
  logic readOutstanding = 1'b0;
  logic respDue;
  logic relDue;

  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      respDue <= 1'b0;
      relDue  <= 1'b0;
    end else begin
      respDue <= readOutstanding;
      relDue  <= respDue && !readOutstanding;
    end
  end

  function automatic int clampInt(input int v, input int maxVal);
    if (v < 0) return 0;
    if (v > maxVal) return maxVal;
    return v;
  endfunction

  task automatic modelReset();
    mdlX      = 79;
    mdlY      = 59;
    mdlCnt    = 8'd0;
    mdlStatus = 8'h00;
    mdlDx     = 8'h00;
    mdlDy     = 8'h00;
    mdlRaise  = 1'b0;
    mdlOvr    = 1'b0;
  endtask

  task automatic modelPacket(input logic [7:0] st, input logic [7:0] dx,
                             input logic [7:0] dy, input logic ackSame);
    int dX;
    int dY;
    dX = st[6] ? 0 : (st[4] ? int'(dx) - 256 : int'(dx));
    dY = st[7] ? 0 : (st[5] ? int'(dy) - 256 : int'(dy));
    if (mdlRaise && !ackSame) mdlOvr = 1'b1;
    mdlRaise  = 1'b1;
    mdlX      = clampInt(mdlX + dX, 159);
    mdlY      = clampInt(mdlY - dY, 119);
    mdlCnt    = mdlCnt + 8'd1;
    mdlStatus = st;
    mdlDx     = dx;
    mdlDy     = dy;
  endtask

  // Queue the value a read of addr must return; reading flags clears overrun.
  task automatic pushExpected(input logic [7:0] addr);
    logic [7:0] e;
    case (addr)
      8'hA0:   e = mdlStatus;
      8'hA1:   e = 8'(mdlX);
      8'hA2:   e = 8'(mdlY);
      8'hA3:   e = mdlDx;
      8'hA4:   e = mdlDy;
      8'hA5:   e = mdlCnt;
      8'hA6:   begin e = {7'd0, mdlOvr}; mdlOvr = 1'b0; end
      default: e = 8'hFF;
    endcase
    expQ.push_back(e);
    addrQ.push_back(addr);
  endtask

  // Advance to the next falling edge and service the read scoreboard.
  task automatic tick();
    logic [7:0] e;
    logic [7:0] a;
    @(negedge clk_sys);
    if (respDue) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL read_response: bus=%h but no read expected", BUS_DATA);
      end else begin
        e = expQ.pop_front();
        a = addrQ.pop_front();
        if (BUS_DATA !== e) begin
          failures++;
          $display("[TB] FAIL read_%h: got %h expected %h", a, BUS_DATA, e);
        end
      end
    end else if (relDue) begin
      checks++;
      if (BUS_DATA !== 8'hFF) begin
        failures++;
        $display("[TB] FAIL bus_release: got %h expected %h (Z)", BUS_DATA, 8'hFF);
      end
    end
  endtask

  task automatic setIdle();
    busIf.BUS_ADDR          = 8'h00;
    busIf.BUS_WE            = 1'b0;
    busIf.MOUSE_STATUS      = 8'h00;
    busIf.MOUSE_DX          = 8'h00;
    busIf.MOUSE_DY          = 8'h00;
    busIf.MOUSE_VALID       = 1'b0;
    busIf.BUS_INTERRUPT_ACK = 1'b0;
    tbDrive                 = 1'b0;
    tbData                  = 8'h00;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    setIdle();
    readOutstanding = 1'b0;
    expQ.delete();
    addrQ.delete();
    modelReset();
    #12;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic issueRead(input logic [7:0] addr);
    tick();
    busIf.BUS_ADDR  = addr;
    busIf.BUS_WE    = 1'b0;
    pushExpected(addr);
    readOutstanding = 1'b1;
    tick();
    busIf.BUS_ADDR  = 8'h00;
    readOutstanding = 1'b0;
  endtask

  task automatic writeReg(input logic [7:0] addr, input logic [7:0] data);
    tick();
    busIf.BUS_ADDR = addr;
    busIf.BUS_WE   = 1'b1;
    tbDrive        = 1'b1;
    tbData         = data;
    if (addr == 8'hA1) mdlX = clampInt(int'(data), 159);
    if (addr == 8'hA2) mdlY = clampInt(int'(data), 119);
    tick();
    busIf.BUS_ADDR = 8'h00;
    busIf.BUS_WE   = 1'b0;
    tbDrive        = 1'b0;
  endtask

  task automatic sendPacket(input logic [7:0] st, input logic [7:0] dx,
                            input logic [7:0] dy);
    tick();
    busIf.MOUSE_STATUS = st;
    busIf.MOUSE_DX     = dx;
    busIf.MOUSE_DY     = dy;
    busIf.MOUSE_VALID  = 1'b1;
    modelPacket(st, dx, dy, 1'b0);
    tick();
    busIf.MOUSE_VALID  = 1'b0;
  endtask

  task automatic ackIrq();
    tick();
    busIf.BUS_INTERRUPT_ACK = 1'b1;
    tick();
    busIf.BUS_INTERRUPT_ACK = 1'b0;
    mdlRaise = 1'b0;
    checks++;
    if (busIf.BUS_INTERRUPT_RAISE !== 1'b0) begin
      failures++;
      $display("[TB] FAIL raise_after_ack: got %b expected 0", busIf.BUS_INTERRUPT_RAISE);
    end
  endtask

  task automatic test_reset();
    doReset();
    tick();
    checks++;
    if (busIf.BUS_INTERRUPT_RAISE !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_raise: got %b expected 0", busIf.BUS_INTERRUPT_RAISE);
    end
    checks++;
    if (BUS_DATA !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL reset_bus_z: got %h expected %h (Z)", BUS_DATA, 8'hFF);
    end
    for (int a = 8'hA0; a <= 8'hA7; a++) issueRead(8'(a));
    issueRead(8'h9F);
  endtask

  task automatic test_back_to_back();
    tick();
    busIf.BUS_ADDR = 8'hA1;
    pushExpected(8'hA1);
    readOutstanding = 1'b1;
    tick();
    busIf.BUS_ADDR = 8'hA2;
    pushExpected(8'hA2);
    tick();
    busIf.BUS_ADDR = 8'hA7;
    pushExpected(8'hA7);
    tick();
    busIf.BUS_ADDR = 8'h00;
    readOutstanding = 1'b0;
    tick();
  endtask

  task automatic test_packet();
    sendPacket(8'h00, 8'd10, 8'd5);
    checks++;
    if (busIf.BUS_INTERRUPT_RAISE !== 1'b1) begin
      failures++;
      $display("[TB] FAIL raise_after_valid: got %b expected 1", busIf.BUS_INTERRUPT_RAISE);
    end
    issueRead(8'hA1);
    issueRead(8'hA2);
    issueRead(8'hA5);
    issueRead(8'hA3);
    issueRead(8'hA4);
    checks++;
    if (busIf.BUS_INTERRUPT_RAISE !== 1'b1) begin
      failures++;
      $display("[TB] FAIL raise_hold: got %b expected 1", busIf.BUS_INTERRUPT_RAISE);
    end
    ackIrq();
  endtask

  task automatic test_clamp();
    writeReg(8'hA1, 8'd150);
    issueRead(8'hA1);
    sendPacket(8'h00, 8'd20, 8'd0);
    issueRead(8'hA1);
    ackIrq();
    sendPacket(8'h10, 8'h80, 8'd0);
    issueRead(8'hA1);
    ackIrq();
    sendPacket(8'h10, 8'h80, 8'd0);
    issueRead(8'hA1);
    ackIrq();
    writeReg(8'hA2, 8'd200);
    issueRead(8'hA2);
    writeReg(8'hA0, 8'h55);
    writeReg(8'hA5, 8'h33);
    issueRead(8'hA0);
    issueRead(8'hA5);
  endtask

  task automatic test_overflow();
    sendPacket(8'h40, 8'd50, 8'd3);
    issueRead(8'hA1);
    issueRead(8'hA2);
    issueRead(8'hA0);
    issueRead(8'hA3);
    ackIrq();
    sendPacket(8'h20, 8'd0, 8'hFB);
    issueRead(8'hA2);
    ackIrq();
  endtask

  task automatic test_overrun();
    sendPacket(8'h00, 8'd1, 8'd1);
    sendPacket(8'h00, 8'd1, 8'd1);
    issueRead(8'hA6);
    issueRead(8'hA6);
    issueRead(8'hA1);
    ackIrq();
  endtask

  task automatic test_races();
    sendPacket(8'h00, 8'd0, 8'd0);
    // Packet and acknowledge together: raise stays, no overrun.
    tick();
    busIf.MOUSE_STATUS      = 8'h00;
    busIf.MOUSE_DX          = 8'd2;
    busIf.MOUSE_DY          = 8'd0;
    busIf.MOUSE_VALID       = 1'b1;
    busIf.BUS_INTERRUPT_ACK = 1'b1;
    modelPacket(8'h00, 8'd2, 8'd0, 1'b1);
    tick();
    busIf.MOUSE_VALID       = 1'b0;
    busIf.BUS_INTERRUPT_ACK = 1'b0;
    checks++;
    if (busIf.BUS_INTERRUPT_RAISE !== 1'b1) begin
      failures++;
      $display("[TB] FAIL raise_valid_ack: got %b expected 1", busIf.BUS_INTERRUPT_RAISE);
    end
    issueRead(8'hA6);
    // Flags read-clear and overrun set together: set wins, old value returned.
    tick();
    busIf.BUS_ADDR     = 8'hA6;
    pushExpected(8'hA6);
    readOutstanding    = 1'b1;
    busIf.MOUSE_STATUS = 8'h00;
    busIf.MOUSE_DX     = 8'd1;
    busIf.MOUSE_DY     = 8'd0;
    busIf.MOUSE_VALID  = 1'b1;
    modelPacket(8'h00, 8'd1, 8'd0, 1'b0);
    tick();
    busIf.BUS_ADDR     = 8'h00;
    readOutstanding    = 1'b0;
    busIf.MOUSE_VALID  = 1'b0;
    issueRead(8'hA6);
    issueRead(8'hA6);
    ackIrq();
    // Bus write to X together with a packet: write wins for X only.
    tick();
    busIf.BUS_ADDR     = 8'hA1;
    busIf.BUS_WE       = 1'b1;
    tbDrive            = 1'b1;
    tbData             = 8'd5;
    busIf.MOUSE_STATUS = 8'h00;
    busIf.MOUSE_DX     = 8'd10;
    busIf.MOUSE_DY     = 8'd2;
    busIf.MOUSE_VALID  = 1'b1;
    modelPacket(8'h00, 8'd10, 8'd2, 1'b0);
    mdlX = 5;
    tick();
    setIdle();
    issueRead(8'hA1);
    issueRead(8'hA2);
    issueRead(8'hA3);
    issueRead(8'hA5);
    ackIrq();
  endtask

  task automatic test_wrap();
    doReset();
    tick();
    busIf.MOUSE_VALID = 1'b1;
    for (int i = 0; i < 256; i++) begin
      modelPacket(8'h00, 8'd0, 8'd0, 1'b0);
      tick();
    end
    busIf.MOUSE_VALID = 1'b0;
    issueRead(8'hA5);
    issueRead(8'hA1);
    issueRead(8'hA2);
    issueRead(8'hA6);
  endtask

  task automatic test_reset_mid_read();
    writeReg(8'hA1, 8'd10);
    tick();
    busIf.BUS_ADDR  = 8'hA1;
    readOutstanding = 1'b1;
    @(posedge clk_sys);
    #2;
    checks++;
    if (BUS_DATA !== 8'd10) begin
      failures++;
      $display("[TB] FAIL mid_read_data: got %h expected %h", BUS_DATA, 8'd10);
    end
    readOutstanding = 1'b0;
    busIf.BUS_ADDR  = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (BUS_DATA !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL reset_abort_bus: got %h expected %h (Z)", BUS_DATA, 8'hFF);
    end
    checks++;
    if (busIf.BUS_INTERRUPT_RAISE !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_abort_raise: got %b expected 0", busIf.BUS_INTERRUPT_RAISE);
    end
    modelReset();
    tick();
    rst_n = 1'b1;
    for (int a = 8'hA0; a <= 8'hA6; a++) issueRead(8'(a));
  endtask

  initial begin
    rst_n = 1'b0;
    setIdle();
    modelReset();
    test_reset();
    test_back_to_back();
    test_packet();
    test_clamp();
    test_overflow();
    test_overrun();
    test_races();
    test_wrap();
    test_reset_mid_read();
    tick();
    tick();
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d reads unanswered, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mouse_bus_regs.md
Name: mouse_bus_regs

Overview:
- Read-side bus responder on the processor data bus; the counterpart to the write-only display peripheral.
- Takes decoded 3-byte mouse packets from the PS/2 mouse receiver and accumulates a clamped absolute pointer position.
- Exposes position and packet state as readable registers at 0xA0-0xA6.
- Raises a bus interrupt per packet until the processor acknowledges it.

Parameters:
- BASE_ADDR, 8'hA0, first register address; occupies BASE_ADDR..BASE_ADDR+6.
- MAX_X, 8'd159, upper X clamp (inclusive).
- MAX_Y, 8'd119, upper Y clamp (inclusive).

Ports:
- clk_sys  input  1  system clock (50MHz)
- rst_n  input  1  reset
- BUS_DATA  inout  8  shared data bus; driven only during a read response, else Z
- BUS_ADDR  input  8  bus address
- BUS_WE  input  1  1 = processor write, 0 = read/idle
- MOUSE_STATUS  input  8  packet byte 0: [4]=X sign, [5]=Y sign, [6]=X ovf, [7]=Y ovf, [2:0]=buttons
- MOUSE_DX  input  8  packet byte 1, X magnitude (low 8 bits of 9-bit two's complement)
- MOUSE_DY  input  8  packet byte 2
- MOUSE_VALID  input  1  one-cycle strobe; bytes valid this cycle
- BUS_INTERRUPT_RAISE  output  1  interrupt request to processor
- BUS_INTERRUPT_ACK  input  1  one-cycle acknowledge from processor

Behaviour:
- Interface: one clock, clk_sys. Reset rst_n is asynchronous, active-low.
- Reset values:
  - pos_x = MAX_X>>1 (79), pos_y = MAX_Y>>1 (59).
  - status/dx/dy/pkt_cnt/overrun = 0.
  - BUS_INTERRUPT_RAISE = 0, read enable = 0, so BUS_DATA = Z.
- Reset mid-operation aborts any read response immediately (bus released the same instant).
- Register map, offsets from BASE_ADDR:
  - +0 status (RO)
  - +1 pos_x (RW)
  - +2 pos_y (RW)
  - +3 dx raw (RO)
  - +4 dy raw (RO)
  - +5 pkt_cnt (RO)
  - +6 flags (RO, bit0 = overrun, bits[7:1] = 0)
- Read timing:
  - In cycle N, if BUS_WE=0 and BUS_ADDR is in range, register rd_data and set rd_en=1.
  - In cycle N+1, BUS_DATA = rd_data. Otherwise rd_en=0 and BUS_DATA = Z.
  - Latency is exactly 1 cycle; an out-of-range address never drives the bus.
- Writes: BUS_WE=1 to +1/+2 loads the position, clamped (value > MAX loads MAX). Writes to other offsets are ignored.
- Packet update, on MOUSE_VALID:
  - Latch status/dx/dy.
  - pkt_cnt += 1, wrapping 255 -> 0.
  - Signed delta: dX = {STATUS[4], DX} as 9-bit two's complement; same for Y.
  - Axis overflow bit set: that axis delta is forced to 0.
  - pos_x' = clamp(pos_x + dX, 0, MAX_X).
  - pos_y' = clamp(pos_y - dY, 0, MAX_Y); Y is inverted because screen origin is top-left.
  - Use 10-bit signed intermediate; below 0 -> 0, above MAX -> MAX.
  - New values are visible to a read issued the cycle after MOUSE_VALID.
- Simultaneous bus write to an axis and MOUSE_VALID: the bus write wins for that axis. The other axis and the latched bytes/counter update normally.
- Interrupt:
  - RAISE goes to 1 the cycle after MOUSE_VALID and holds until a cycle with ACK=1, then goes to 0 the next cycle.
  - VALID and ACK in the same cycle: RAISE stays/becomes 1 (raise wins).
- Overrun:
  - Set when MOUSE_VALID arrives while RAISE=1 and ACK=0.
  - Cleared on read of +6 (clears in the cycle the read is captured; returned data is the pre-clear value).
  - Set and clear in the same cycle: set wins.

Decomposition:
- Shared package mouse_bus_pkg:
  - register offset constants (OFS_STATUS..OFS_FLAGS)
  - status bit-index constants (X_SIGN=4, Y_SIGN=5, X_OVF=6, Y_OVF=7)
- Sub-module mouse_axis_accum (one instance per axis):
  - parameters MAX and INVERT
  - inputs: delta, sign, ovf, update strobe, load strobe, load data
  - output: 8-bit clamped position
  - contains the 10-bit signed add and clamp, plus the write-wins priority

Test Plan:
- Reset then read 0xA1, 0xA2 -> BUS_DATA = 79, 59 one cycle after address; Z on all other cycles; RAISE=0.
- VALID with STATUS=0x00, DX=10, DY=5 -> pos_x=89, pos_y=54, pkt_cnt=1; RAISE=1 next cycle; ACK pulse -> RAISE=0 the following cycle.
- Clamping:
  - Write 0xA1=150, then VALID DX=20 (positive) -> pos_x=159.
  - VALID STATUS[4]=1, DX=0x80 (-128) -> pos_x=31.
  - Repeat the -128 packet -> pos_x=0.
  - Write 0xA2=200 -> reads 119.
- Overflow: VALID STATUS=0x40, DX=50, DY=3 -> pos_x unchanged, pos_y decreases by 3; status reads 0x40.
- Overrun and races:
  - Two VALIDs with no ACK between -> flags read 0x01, then a re-read returns 0x00.
  - VALID and ACK in the same cycle -> RAISE=1.
  - Bus write 0xA1=5 in the same cycle as VALID DX=10 -> pos_x=5.
- Wrap and reset: 256 VALID strobes -> pkt_cnt=0; assert rst_n low during a read-response cycle -> BUS_DATA goes Z immediately and all registers return to reset values.
